// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring CORDIC engine (16-bit words).
package cordic_pkg;

  localparam int CORDIC_N = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // atan(2^-j) in Q3.13, rounded to nearest
  localparam logic signed [CORDIC_N-1:0] ATAN_LUT [CORDIC_N] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
    16'sd511,  16'sd256,  16'sd128,  16'sd64,
    16'sd32,   16'sd16,   16'sd8,    16'sd4,
    16'sd2,    16'sd1,    16'sd1,    16'sd0
  };

  // pi and pi/2 in Q3.13
  localparam logic signed [CORDIC_N-1:0] PI   = 16'sd25736;
  localparam logic signed [CORDIC_N-1:0] PI_2 = 16'sd12868;

  // 1/K = 0.607253 in Q1.15
  localparam logic [CORDIC_N-1:0] INV_K = 16'd19898;

endpackage

// File: rtl/cordic_vec_iter.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the angle.
module cordic_vec_iter #(
  parameter int W  = 18,
  parameter int SW = 4
) (
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic signed [W-1:0]  i_z,
  input  logic signed [W-1:0]  i_alpha,
  input  logic        [SW-1:0] i_shift,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic signed [W-1:0]  o_z
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;

  assign w_xs = i_x >>> i_shift;
  assign w_ys = i_y >>> i_shift;

  // rotate against the sign of y; all terms use pre-update values
  always_comb begin
    o_x = i_x + w_ys;
    o_y = i_y - w_xs;
    o_z = i_z + i_alpha;
    if (i_y[W-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_alpha;
    end
  end

endmodule

// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude, angle), one micro-rotation per clock.
module cordic_vectoring_engine
  import cordic_pkg::*;
#(
  parameter int N         = CORDIC_N,
  parameter int ITERS     = 14,
  parameter int GAIN_COMP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [N-1:0] mag_out,
  output logic signed [N-1:0] ang_out,
  output logic                zero_out
);

  localparam int W  = N + 2;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * N + 3;
  localparam logic signed [PW-1:0] MAG_MAX = {{(N+4){1'b0}}, {(N-1){1'b1}}};

  state_t r_state, w_state_next;
  logic [CW-1:0]       r_cnt;
  logic signed [W-1:0] r_x, r_y, r_z, r_alpha;
  logic                r_zero;
  logic [N-1:0]        r_mag;
  logic signed [N-1:0] r_ang;
  logic                r_zero_out;

  logic                       w_accept;
  logic signed [W-1:0]        w_x_ext, w_y_ext, w_pi2_ext;
  logic signed [W-1:0]        w_ld_x, w_ld_y, w_ld_z;
  logic signed [W-1:0]        w_nx, w_ny, w_nz;
  logic signed [CORDIC_N-1:0] w_lut;
  logic [CW-1:0]              w_shift;
  logic signed [PW-1:0]       w_prod, w_mag_full;
  logic [N-1:0]               w_mag_sat;
  logic                       w_unused_zhi;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_x_ext   = {{2{x_in[N-1]}}, x_in};
  assign w_y_ext   = {{2{y_in[N-1]}}, y_in};
  assign w_pi2_ext = {{(W-CORDIC_N){PI_2[CORDIC_N-1]}}, PI_2};
  assign w_lut     = ATAN_LUT[r_cnt];
  // the angle ROM is read one cycle ahead, so iteration j runs while r_cnt = j+1
  assign w_shift   = r_cnt - 1'b1;

  assign mag_out      = r_mag;
  assign ang_out      = r_ang;
  assign zero_out     = r_zero_out;
  assign w_unused_zhi = ^r_z[W-1:N];

  cordic_vec_iter #(.W(W), .SW(CW)) u_iter (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_alpha (r_alpha),
    .i_shift (w_shift),
    .o_x     (w_nx),
    .o_y     (w_ny),
    .o_z     (w_nz)
  );

  // fold left-half-plane inputs into the right half plane by a +/-90 degree turn
  always_comb begin
    w_ld_x = w_x_ext;
    w_ld_y = w_y_ext;
    w_ld_z = '0;
    if (x_in[N-1]) begin
      if (!y_in[N-1]) begin
        w_ld_x = w_y_ext;
        w_ld_y = -w_x_ext;
        w_ld_z = w_pi2_ext;
      end else begin
        w_ld_x = -w_y_ext;
        w_ld_y = w_x_ext;
        w_ld_z = -w_pi2_ext;
      end
    end
  end

  assign w_prod = r_x * $signed({1'b0, INV_K});

  // gain compensation and clamp to the non-negative output range
  always_comb begin
    w_mag_full = {{(PW-W){r_x[W-1]}}, r_x};
    if (GAIN_COMP != 0) w_mag_full = w_prod >>> (N - 1);
    w_mag_sat = w_mag_full[N-1:0];
    if (r_zero || w_mag_full < 0) w_mag_sat = '0;
    else if (w_mag_full > MAG_MAX) w_mag_sat = MAG_MAX[N-1:0];
  end

  // next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ITER;
      end
      ITER:  if (r_cnt == CW'(ITERS)) w_state_next = FINAL;
      FINAL: w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // datapath: load, iterate, and register the final result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_alpha    <= '0;
      r_zero     <= 1'b0;
      r_mag      <= '0;
      r_ang      <= '0;
      r_zero_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x    <= w_ld_x;
            r_y    <= w_ld_y;
            r_z    <= w_ld_z;
            r_cnt  <= '0;
            r_zero <= (x_in == '0) && (y_in == '0);
          end
        end
        ITER: begin
          r_alpha <= {{(W-CORDIC_N){w_lut[CORDIC_N-1]}}, w_lut};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt != '0) begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_z <= w_nz;
          end
        end
        FINAL: begin
          r_mag      <= w_mag_sat;
          r_ang      <= r_zero ? '0 : r_z[N-1:0];
          r_zero_out <= r_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Self-checking bench: directed and random vectors against a real-arithmetic polar model.
module tb_cordic_vectoring_engine;

  localparam int  N     = 16;
  localparam int  ITERS = 14;
  localparam int  LAT   = ITERS + 2;
  localparam real PI_R  = 3.14159265358979;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [N-1:0] x_in = '0;
  logic signed [N-1:0] y_in = '0;
  logic                in_ready, out_valid, zero_out;
  logic        [N-1:0] mag_out;
  logic signed [N-1:0] ang_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_vectoring_engine #(.N(N), .ITERS(ITERS), .GAIN_COMP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .ang_out   (ang_out),
    .zero_out  (zero_out)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // present one vector, return cycles from accepting edge to out_valid
  task automatic send(input int x, input int y, output int lat);
    @(negedge clk);
    x_in     = N'(x);
    y_in     = N'(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // compare the presented result with the polar form of (x, y)
  task automatic expect_result(input string tag, input int x, input int y,
                               input int tol_m, input int tol_a, input int lat);
    int  exp_m, exp_a, exp_z;
    real xr, yr;
    xr = real'(x) / 16384.0;
    yr = real'(y) / 16384.0;
    if (x == 0 && y == 0) begin
      exp_m = 0; exp_a = 0; exp_z = 1; tol_m = 0; tol_a = 0;
    end else begin
      exp_m = rnd($sqrt(xr * xr + yr * yr) * 16384.0);
      exp_a = rnd($atan2(yr, xr) * 8192.0);
      exp_z = 0;
    end
    $display("vec %s x=%0d y=%0d mag=%0d ang=%0d zero=%0d lat=%0d", tag, x, y,
             mag_out, ang_out, zero_out, lat);
    check({tag, ".lat"}, lat, LAT, 0);
    check({tag, ".valid"}, int'(out_valid), 1, 0);
    check({tag, ".mag"}, int'(mag_out), exp_m, tol_m);
    check({tag, ".ang"}, int'(ang_out), exp_a, tol_a);
    check({tag, ".zero"}, int'(zero_out), exp_z, 0);
  endtask

  // complete the output handshake and confirm return to idle
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".ready_after"}, int'(in_ready), 1, 0);
    check({tag, ".valid_after"}, int'(out_valid), 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, xs, ys, hold_m, hold_a, ghost;
    int dx[7] = '{8192, 8192, 8192, -8192, 0, -8192, 0};
    int dy[7] = '{0, 8192, -8192, 0, -8192, -8192, 0};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", int'(in_ready), 1, 0);
    check("rst.out_valid", int'(out_valid), 0, 0);
    check("rst.mag", int'(mag_out), 0, 0);
    check("rst.ang", int'(ang_out), 0, 0);
    check("rst.zero", int'(zero_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed quadrant, axis and zero cases
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(dx[i], dy[i], lat);
      expect_result($sformatf("dir%0d", i), dx[i], dy[i], 6, 6, lat);
      consume($sformatf("dir%0d", i));
    end

    // stalled result: outputs held, new inputs ignored
    out_ready = 1'b0;
    send(8192, 4096, lat);
    expect_result("stall", 8192, 4096, 6, 6, lat);
    hold_m = int'(mag_out);
    hold_a = int'(ang_out);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x_in = 16'sd1234;
      y_in = -16'sd777;
      in_valid = (c % 2 == 0);
      @(posedge clk);
      #1;
      check("stall.valid", int'(out_valid), 1, 0);
      check("stall.ready", int'(in_ready), 0, 0);
      check("stall.mag", int'(mag_out), hold_m, 0);
      check("stall.ang", int'(ang_out), hold_a, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("stall");
    ghost = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 if (out_valid) ghost++;
    end
    check("stall.ghost", ghost, 0, 0);

    // reset in the middle of the iterations aborts the job
    @(negedge clk);
    x_in = 16'sd8192;
    y_in = 16'sd4096;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.valid", int'(out_valid), 0, 0);
    check("abort.ready", int'(in_ready), 1, 0);
    check("abort.mag", int'(mag_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16384, 0, lat);
    expect_result("abort.next", 16384, 0, 6, 6, lat);
    consume("abort.next");

    // random legal vectors with magnitude of at least 0.5
    for (int i = 0; i < 20; i++) begin
      do begin
        xs = int'($urandom_range(32768, 0)) - 16384;
        ys = int'($urandom_range(32768, 0)) - 16384;
      end while (real'(xs) * real'(xs) + real'(ys) * real'(ys) < 8192.0 * 8192.0);
      send(xs, ys, lat);
      expect_result($sformatf("rnd%0d", i), xs, ys, 12, 12, lat);
      consume($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
